// File: rtl/riscv_fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, issues one-outstanding imem requests
// and holds the IF/ID pipeline register with a one-entry skid buffer for stalls.
//
// state | meaning
// FETCH | request at pc outstanding; accept data into IF/ID or skid
// HOLD  | skid holds a fetched instruction while IF/ID is stalled; no request
// DRAIN | redirected while a request was in flight; wait out and drop its data
module riscv_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic [6:0]  if_id_opcode
);

    typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] drain_addr;
    logic [31:0] skid_pc;
    logic [31:0] skid_instr;

    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= state_nxt;
    end

    // A redirect landing in DRAIN together with imem_ready still completes the drain.
    always_comb begin
        state_nxt = state;
        case (state)
            FETCH: begin
                if (redirect_valid)
                    state_nxt = imem_ready ? FETCH : DRAIN;
                else if (imem_ready && stall && if_id_valid)
                    state_nxt = HOLD;
            end
            HOLD:    if (redirect_valid || !stall) state_nxt = FETCH;
            DRAIN:   if (imem_ready) state_nxt = FETCH;
            default: state_nxt = FETCH;
        endcase
    end

    always_comb begin
        imem_req  = !rst && (state != HOLD);
        imem_addr = (state == DRAIN) ? drain_addr : pc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            drain_addr  <= RESET_PC;
            skid_pc     <= 32'h0;
            skid_instr  <= NOP_INSTR;
            if_id_valid <= 1'b0;
            if_id_pc    <= 32'h0;
            if_id_instr <= NOP_INSTR;
        end else if (redirect_valid) begin
            pc          <= redirect_pc & ~32'h3;
            if_id_valid <= 1'b0;
            if_id_instr <= NOP_INSTR;
            if (state == FETCH && !imem_ready)
                drain_addr <= pc;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ready) begin
                        if (!stall || !if_id_valid) begin
                            if_id_valid <= 1'b1;
                            if_id_pc    <= pc;
                            if_id_instr <= imem_rdata;
                        end else begin
                            skid_pc    <= pc;
                            skid_instr <= imem_rdata;
                        end
                        pc <= pc + 32'd4;
                    end else if (!stall) begin
                        if_id_valid <= 1'b0;
                        if_id_instr <= NOP_INSTR;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        if_id_valid <= 1'b1;
                        if_id_pc    <= skid_pc;
                        if_id_instr <= skid_instr;
                    end
                end
                default: begin
                    if (!stall) begin
                        if_id_valid <= 1'b0;
                        if_id_instr <= NOP_INSTR;
                    end
                end
            endcase
        end
    end

    assign if_id_opcode = if_id_instr[6:0];

endmodule

// File: tb/tb_riscv_fetch_stage.sv
// Bench for riscv_fetch_stage: directed scenarios plus randomized stall/redirect/wait
// traffic, checked every cycle against a transaction-level model of the fetch stage.
module tb_riscv_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic [6:0]  if_id_opcode;

    riscv_fetch_stage dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
        .if_id_instr(if_id_instr), .if_id_opcode(if_id_opcode)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: pending fetched-but-blocked instructions live in a queue,
    // an abandoned in-flight request is a flag plus its address.
    typedef struct { logic [31:0] pc; logic [31:0] instr; } entry_t;
    entry_t      skid_q[$];
    logic [31:0] m_pc;
    logic        m_discard;
    logic [31:0] m_drain;
    logic        m_valid;
    logic [31:0] m_ipc;
    logic [31:0] m_instr;

    // Memory side: wait_cfg < 0 picks 0..2 wait states per request at random.
    int wait_cfg = 0;
    int wait_left = 0;
    bit need_new = 1'b1;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        case (a)
            32'h0:   memfn = 32'h0050_0093;
            32'h4:   memfn = 32'h0010_8133;
            32'h8:   memfn = 32'h0000_2083;
            default: memfn = (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
        endcase
    endfunction

    task automatic model_reset();
        skid_q.delete();
        m_pc = 32'h0; m_discard = 1'b0; m_drain = 32'h0;
        m_valid = 1'b0; m_ipc = 32'h0; m_instr = NOP;
    endtask

    task automatic model_update(input logic st, input logic rd, input logic [31:0] rpc,
                                input logic rdy, input logic [31:0] rdat);
        bit     holding;
        entry_t e;
        holding = (skid_q.size() > 0);
        if (rd) begin
            if (m_discard) begin
                if (rdy) m_discard = 1'b0;
            end else if (!holding && !rdy) begin
                m_discard = 1'b1;
                m_drain   = m_pc;
            end
            skid_q.delete();
            m_valid = 1'b0; m_instr = NOP;
            m_pc = {rpc[31:2], 2'b00};
        end else if (m_discard) begin
            if (rdy) m_discard = 1'b0;
            if (!st) begin m_valid = 1'b0; m_instr = NOP; end
        end else if (holding) begin
            if (!st) begin
                e = skid_q.pop_front();
                m_valid = 1'b1; m_ipc = e.pc; m_instr = e.instr;
            end
        end else if (rdy) begin
            if (!st || !m_valid) begin
                m_valid = 1'b1; m_ipc = m_pc; m_instr = rdat;
            end else begin
                e.pc = m_pc; e.instr = rdat;
                skid_q.push_back(e);
            end
            m_pc = m_pc + 32'd4;
        end else if (!st) begin
            m_valid = 1'b0; m_instr = NOP;
        end
    endtask

    // One cycle: compare outputs against the model, then drive inputs for the next edge.
    task automatic tick(input logic st, input logic rd, input logic [31:0] rpc);
        logic        rdy;
        logic [31:0] rdat;
        logic        exp_req;
        logic [31:0] exp_addr;
        @(negedge clk);
        exp_req  = (skid_q.size() == 0);
        exp_addr = m_discard ? m_drain : m_pc;
        checks++;
        if (imem_req !== exp_req) begin
            errors++; $display("FAIL imem_req: got %b expected %b at %0t", imem_req, exp_req, $time);
        end
        if (exp_req) begin
            checks++;
            if (imem_addr !== exp_addr) begin
                errors++; $display("FAIL imem_addr: got %h expected %h at %0t", imem_addr, exp_addr, $time);
            end
        end
        checks++;
        if (if_id_valid !== m_valid) begin
            errors++; $display("FAIL if_id_valid: got %b expected %b at %0t", if_id_valid, m_valid, $time);
        end
        checks++;
        if (if_id_pc !== m_ipc) begin
            errors++; $display("FAIL if_id_pc: got %h expected %h at %0t", if_id_pc, m_ipc, $time);
        end
        checks++;
        if (if_id_instr !== m_instr || if_id_opcode !== m_instr[6:0]) begin
            errors++; $display("FAIL if_id_instr: got %h/%h expected %h at %0t", if_id_instr, if_id_opcode, m_instr, $time);
        end
        rdy  = 1'b0;
        rdat = $urandom;
        if (imem_req) begin
            if (need_new) begin
                wait_left = (wait_cfg < 0) ? $urandom_range(0, 2) : wait_cfg;
                need_new  = 1'b0;
            end
            if (wait_left == 0) begin
                rdy = 1'b1; rdat = memfn(imem_addr); need_new = 1'b1;
            end else begin
                wait_left--;
            end
        end
        stall = st; redirect_valid = rd; redirect_pc = rpc;
        imem_ready = rdy; imem_rdata = rdat;
        model_update(st, rd, rpc, rdy, rdat);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; imem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || if_id_valid !== 1'b0 || if_id_pc !== 32'h0 ||
            if_id_instr !== NOP || if_id_opcode !== 7'h13) begin
            errors++;
            $display("FAIL reset: got req=%b valid=%b pc=%h instr=%h op=%h expected 0 0 0 00000013 13",
                     imem_req, if_id_valid, if_id_pc, if_id_instr, if_id_opcode);
        end
        rst = 1'b0;
        need_new = 1'b1;
        model_reset();
        model_update(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic test_zero_wait();
        test_reset();
        wait_cfg = 0;
        tick(0, 0, 0);
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL zw_addr0: got %h expected 0", imem_addr); end
        tick(0, 0, 0);
        checks++; if (imem_addr !== 32'h4 || if_id_pc !== 32'h0 || if_id_opcode !== 7'h13) begin
            errors++; $display("FAIL zw_cycle1: got addr=%h pc=%h op=%h expected 4 0 13", imem_addr, if_id_pc, if_id_opcode); end
        tick(0, 0, 0);
        checks++; if (imem_addr !== 32'h8 || if_id_pc !== 32'h4 || if_id_opcode !== 7'h33) begin
            errors++; $display("FAIL zw_cycle2: got addr=%h pc=%h op=%h expected 8 4 33", imem_addr, if_id_pc, if_id_opcode); end
    endtask

    task automatic test_wait_states();
        test_reset();
        wait_cfg = 0;
        tick(0, 0, 0);
        wait_cfg = 2;
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0);
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
                errors++; $display("FAIL ws_hold: got req=%b addr=%h expected 1 4", imem_req, imem_addr); end
            if (i > 0) begin
                checks++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP) begin
                    errors++; $display("FAIL ws_bubble: got valid=%b instr=%h expected 0 00000013", if_id_valid, if_id_instr); end
            end
        end
        wait_cfg = 0;
        tick(0, 0, 0);
        tick(0, 0, 0);
    endtask

    task automatic test_stall_hold();
        test_reset();
        wait_cfg = 0;
        tick(0, 0, 0);
        tick(0, 0, 0);
        tick(1, 0, 0);
        tick(1, 0, 0);
        checks++; if (imem_req !== 1'b0 || if_id_pc !== 32'h4 || if_id_valid !== 1'b1) begin
            errors++; $display("FAIL hold: got req=%b pc=%h valid=%b expected 0 4 1", imem_req, if_id_pc, if_id_valid); end
        tick(0, 0, 0);
        tick(0, 0, 0);
        checks++; if (if_id_pc !== 32'h8 || if_id_opcode !== 7'h03 || imem_addr !== 32'hC) begin
            errors++; $display("FAIL unstall: got pc=%h op=%h addr=%h expected 8 03 c", if_id_pc, if_id_opcode, imem_addr); end
    endtask

    task automatic test_redirect_drain();
        test_reset();
        wait_cfg = 0;
        for (int i = 0; i < 4; i++) tick(0, 0, 0);
        wait_cfg = 3;
        tick(0, 1, 32'h200);
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0);
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
                errors++; $display("FAIL drain_addr: got req=%b addr=%h expected 1 10", imem_req, imem_addr); end
        end
        wait_cfg = 0;
        tick(0, 0, 0);
        checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL drain_target: got %h expected 200", imem_addr); end
        tick(0, 0, 0);
        checks++; if (if_id_pc !== 32'h200 || if_id_valid !== 1'b1) begin
            errors++; $display("FAIL drain_first: got pc=%h valid=%b expected 200 1", if_id_pc, if_id_valid); end
    endtask

    task automatic test_redirect_hold();
        test_reset();
        wait_cfg = 0;
        tick(0, 0, 0);
        tick(1, 0, 0);
        tick(1, 0, 0);
        tick(1, 1, 32'h300);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rh_in_hold: got req=%b expected 0", imem_req); end
        tick(1, 0, 0);
        checks++; if (if_id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300) begin
            errors++; $display("FAIL rh_after: got valid=%b req=%b addr=%h expected 0 1 300", if_id_valid, imem_req, imem_addr); end
        tick(0, 0, 0);
        checks++; if (if_id_pc !== 32'h300 || if_id_valid !== 1'b1) begin
            errors++; $display("FAIL rh_target: got pc=%h valid=%b expected 300 1", if_id_pc, if_id_valid); end
    endtask

    task automatic test_align_wrap();
        test_reset();
        wait_cfg = 0;
        tick(0, 1, 32'h103);
        tick(0, 0, 0);
        checks++; if (imem_addr !== 32'h100 || if_id_valid !== 1'b0) begin
            errors++; $display("FAIL align: got addr=%h valid=%b expected 100 0", imem_addr, if_id_valid); end
        tick(0, 1, 32'hFFFF_FFFC);
        tick(0, 0, 0);
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_from: got %h expected fffffffc", imem_addr); end
        tick(0, 0, 0);
        checks++; if (imem_addr !== 32'h0 || if_id_pc !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL wrap_to: got addr=%h pc=%h expected 0 fffffffc", imem_addr, if_id_pc); end
    endtask

    task automatic test_random();
        test_reset();
        wait_cfg = -1;
        for (int i = 0; i < 4000; i++) begin
            if (i % 1000 == 999) begin
                test_reset();
            end else begin
                tick(($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 8), $urandom);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall_hold();
        test_redirect_drain();
        test_redirect_hold();
        test_align_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
